mux_arb_reg: RTL
================

Name: mux_arb_reg

Overview:
- Parametrised successor of the 4:1 selector.
- Merges CH input channels of N-bit words into one registered output stream with valid/ready handshakes.
- Two modes:
  - manual: the channel index comes from selecm.
  - round-robin: fair rotation over the channels that have data.
- Sits between producer registers and a single shared consumer, for example a shared ALU operand bus.

Parameters:
- N, 16, data width per channel.
- CH, 4, number of input channels (CH >= 2, need not be a power of two).
- SELW, $clog2(CH), width of the channel index. Derived value, never overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- mode  input  1  0 = manual select, 1 = round-robin.
- selecm  input  SELW  channel index used in manual mode.
- R_in  input  CH*N  flattened channel data; channel k is bits [k*N +: N].
- valid_in  input  CH  per-channel data valid.
- ready_in  output  CH  per-channel accept; combinational, at most one bit high (one-hot or zero).
- q  output  N  registered output data.
- q_valid  output  1  q holds a word not yet taken.
- q_chan  output  SELW  index of the channel that produced q.
- q_ready  input  1  consumer accepts q this cycle.

Behaviour:
- Reset (reset==0 at a clock edge):
  - q=0, q_valid=0, q_chan=0, rr_ptr=0.
  - ready_in is forced to all-zero while reset is low.
  - Reset in the middle of a transfer discards the held word; nothing is transferred on that edge.
- load = !q_valid || q_ready. The output slot is free, or is being emptied this cycle.
- Grant g (combinational):
  - Manual mode: g = selecm if selecm < CH and valid_in[selecm]=1. Otherwise no grant.
  - Round-robin mode: g = first k with valid_in[k]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo CH. No grant if valid_in is all-zero.
- ready_in[g] = load when a grant exists. All other ready_in bits are 0.
- Transfer edge, when a grant exists and load=1:
  - q <= R_in channel g.
  - q_chan <= g.
  - q_valid <= 1.
  - rr_ptr <= (g+1) mod CH, with wrap from CH-1 to 0. rr_ptr updates in both modes.
- Drain edge, when there is no grant and q_valid && q_ready: q_valid <= 0. q and q_chan hold their values.
- Stall, when q_valid && !q_ready:
  - q, q_valid and q_chan hold.
  - ready_in is all-zero.
  - Input changes are ignored.
- Latency:
  - One cycle from an input handshake to q_valid.
  - Full throughput of one word per cycle when q_ready is held at 1.
- Simultaneous output handshake and new grant: the new word replaces the old one on the same edge, and q_valid stays 1 (no bubble).
- Changes to mode or selecm take effect combinationally on the next grant. rr_ptr is never reset by a mode change.
- Out-of-range selecm (possible when CH is not a power of two): no grant, no X propagation.
- No combinational path from q_ready to q. There is a combinational path q_ready -> ready_in, and it is intended.

Test Plan:
- Reset values: hold reset=0 for 2 edges with all valid_in=1.
  - Required: q=0, q_valid=0, q_chan=0, ready_in=0.
  - Release reset with valid_in=0: outputs stay at those values.
- Manual mode, mode=0, selecm=2, channel 2 = 0xBEEF, valid_in=4'b0100, q_ready=1.
  - Required: ready_in=4'b0100.
  - Next edge: q=0xBEEF, q_chan=2, q_valid=1.
  - Then with selecm=3 and valid_in[3]=0: no grant, q_valid drops to 0 after one edge.
- Round-robin fairness, mode=1, valid_in=4'b1111 constant, q_ready=1, channel k = 0x1000+k.
  - Required q sequence: 0x1000, 0x1001, 0x1002, 0x1003, 0x1000 on consecutive edges (wrap checked).
- Round-robin skipping, valid_in=4'b1010.
  - Required: grants alternate 1, 3, 1, 3.
  - Channels 0 and 2 never see ready_in high.
- Backpressure: with q_valid=1 and q=0x1001, hold q_ready=0 for 3 cycles while inputs change.
  - Required: q stays 0x1001, ready_in=0.
  - Raise q_ready: the next word loads on that same edge with no bubble cycle.
- Reset mid-stream: assert reset=0 while q_valid=1 and q_ready=0.
  - Required: q_valid=0 and rr_ptr=0 after the edge.
  - First round-robin grant after reset with valid_in=4'b1111 is channel 0.

Source files
------------

// File: rtl/mux_arb_reg.sv
// mux_arb_reg: merges CH valid/ready input channels of N-bit words into a
// single registered output stream. The channel is picked either manually
// through selecm or by a round-robin search that starts at rr_ptr. The
// output slot reloads on the same edge it is emptied, so the stream runs
// at one word per cycle while the consumer keeps q_ready high.
module mux_arb_reg #(
    parameter int N  = 16,
    parameter int CH = 4,
    localparam int SELW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mode,
    input  logic [SELW-1:0] selecm,
    input  logic [CH*N-1:0] R_in,
    input  logic [CH-1:0]   valid_in,
    output logic [CH-1:0]   ready_in,
    output logic [N-1:0]    q,
    output logic            q_valid,
    output logic [SELW-1:0] q_chan,
    input  logic            q_ready
);

    logic [SELW-1:0] rr_ptr;
    logic            grant_valid;
    logic [SELW-1:0] grant;
    logic [N-1:0]    grant_data;
    logic            load;

    // The slot may take a new word when it is empty or being emptied now.
    assign load = !q_valid || q_ready;

    // Grant selection: manual takes selecm only if that channel is valid and
    // in range; round-robin takes the first valid channel at or after rr_ptr.
    // Offsets are scanned from the far end so the nearest one wins last.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        if (mode == 1'b0) begin
            for (int k = 0; k < CH; k++) begin
                if (selecm == SELW'(k) && valid_in[k]) begin
                    grant_valid = 1'b1;
                    grant       = SELW'(k);
                end
            end
        end else begin
            for (int i = CH - 1; i >= 0; i--) begin
                for (int k = 0; k < CH; k++) begin
                    if (valid_in[k] && (k == (int'(rr_ptr) + i) % CH)) begin
                        grant_valid = 1'b1;
                        grant       = SELW'(k);
                    end
                end
            end
        end
    end

    // Route the granted channel's word toward the output register.
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < CH; k++) begin
            if (grant == SELW'(k)) begin
                grant_data = R_in[k*N +: N];
            end
        end
    end

    // Accept strobe goes only to the granted channel, only when the slot can
    // load, and never while reset is held low.
    always_comb begin
        ready_in = '0;
        for (int k = 0; k < CH; k++) begin
            ready_in[k] = reset && grant_valid && load && (grant == SELW'(k));
        end
    end

    // Output slot and rotation pointer: load on a grant, drain when the
    // consumer takes the word with nothing new to replace it, else hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q       <= '0;
            q_valid <= 1'b0;
            q_chan  <= '0;
            rr_ptr  <= '0;
        end else if (grant_valid && load) begin
            q       <= grant_data;
            q_chan  <= grant;
            q_valid <= 1'b1;
            rr_ptr  <= (grant == SELW'(CH - 1)) ? '0 : grant + 1'b1;
        end else if (q_valid && q_ready) begin
            q_valid <= 1'b0;
        end
    end

endmodule
